// File: rtl/tt_lfsr_gen_pkg.sv
// Shared constants for the LFSR generator: maximal-length tap masks for widths 4..32
// and small sizing helpers used by the generator and its word packer.
package tt_lfsr_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_OUT_W = 8;
    localparam int MIN_WIDTH     = 4;
    localparam int MAX_WIDTH     = 32;

    typedef logic [MAX_WIDTH-1:0] tap_word_t;

    // Bit i set means state[i] feeds the XOR; each mask is a maximal polynomial.
    function automatic tap_word_t tap_mask_for(input int width);
        tap_word_t mask;
        case (width)
            4:       mask = 32'h0000_000C;
            5:       mask = 32'h0000_0014;
            6:       mask = 32'h0000_0030;
            7:       mask = 32'h0000_0060;
            8:       mask = 32'h0000_00B8;
            9:       mask = 32'h0000_0110;
            10:      mask = 32'h0000_0240;
            11:      mask = 32'h0000_0500;
            12:      mask = 32'h0000_0829;
            13:      mask = 32'h0000_100D;
            14:      mask = 32'h0000_2015;
            15:      mask = 32'h0000_6000;
            16:      mask = 32'h0000_D008;
            17:      mask = 32'h0001_2000;
            18:      mask = 32'h0002_0400;
            19:      mask = 32'h0004_0023;
            20:      mask = 32'h0009_0000;
            21:      mask = 32'h0014_0000;
            22:      mask = 32'h0030_0000;
            23:      mask = 32'h0042_0000;
            24:      mask = 32'h00E1_0000;
            25:      mask = 32'h0120_0000;
            26:      mask = 32'h0200_0023;
            27:      mask = 32'h0400_0013;
            28:      mask = 32'h0900_0000;
            29:      mask = 32'h1400_0000;
            30:      mask = 32'h2000_0029;
            31:      mask = 32'h4800_0000;
            32:      mask = 32'h8020_0003;
            default: mask = '0;
        endcase
        return mask;
    endfunction

    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/tt_lfsr_gen_if.sv
// Seed-load and packed-word channels of the LFSR generator.
// master is the generator side, slave is the seed producer / word consumer.
interface tt_lfsr_gen_if
    import tt_lfsr_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int OUT_W = DEFAULT_OUT_W
);
    logic             seed_valid;
    logic [WIDTH-1:0] seed_data;
    logic             seed_ready;
    logic [OUT_W-1:0] word_data;
    logic             word_valid;
    logic             word_ready;

    modport master (
        input  seed_valid, seed_data, word_ready,
        output seed_ready, word_data, word_valid
    );

    modport slave (
        output seed_valid, seed_data, word_ready,
        input  seed_ready, word_data, word_valid
    );
endinterface

// File: rtl/tt_lfsr_gen_word_pack.sv
// Packs the serial feedback stream into OUT_W-bit words (first bit in the MSB)
// and holds a completed word until the consumer accepts it.
module tt_lfsr_word_pack
    import tt_lfsr_pkg::*;
#(
    parameter int OUT_W = DEFAULT_OUT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             step,
    input  logic             fb,
    input  logic             clear,
    input  logic             word_ready,
    output logic [OUT_W-1:0] word_data,
    output logic             word_valid,
    output logic             full
);
    localparam int CW = cnt_width(OUT_W);
    localparam logic [CW-1:0] LAST = CW'(OUT_W - 1);

    logic [OUT_W-1:0] collector;
    logic [OUT_W-1:0] shifted;
    logic [CW-1:0]    coll_cnt;
    logic             complete;
    logic             accept;

    if (OUT_W > 1) begin : g_wide
        assign shifted = {collector[OUT_W-2:0], fb};
    end else begin : g_single
        assign shifted = fb;
    end

    assign complete = step && (coll_cnt == LAST);
    assign accept   = word_valid && word_ready;
    // Stall only when one more bit would overwrite a word nobody has taken yet.
    assign full     = word_valid && !word_ready && (coll_cnt == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            collector  <= '0;
            coll_cnt   <= '0;
            word_data  <= '0;
            word_valid <= 1'b0;
        end else begin
            if (clear) begin
                collector <= '0;
                coll_cnt  <= '0;
            end else if (step) begin
                collector <= complete ? '0 : shifted;
                coll_cnt  <= complete ? '0 : coll_cnt + CW'(1);
            end

            if (complete) begin
                word_data  <= shifted;
                word_valid <= 1'b1;
            end else if (accept) begin
                word_valid <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/tt_lfsr_gen.sv
// Parametrised Fibonacci LFSR with seed loading, lock-up recovery, period detection
// and serial plus packed-word outputs.
module tt_lfsr_gen
    import tt_lfsr_pkg::*;
#(
    parameter int               WIDTH    = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] TAP_MASK = WIDTH'(tap_mask_for(WIDTH)),
    parameter logic [WIDTH-1:0] SEED     = WIDTH'(1),
    parameter int               OUT_W    = DEFAULT_OUT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    tt_lfsr_gen_if.master    bus,
    output logic             bit_out,
    output logic             bit_valid,
    output logic [WIDTH-1:0] state_out,
    output logic             period_done,
    output logic [WIDTH-1:0] step_count,
    output logic             lockup
);
    logic [WIDTH-1:0] state;
    logic [WIDTH-1:0] loaded_seed;
    logic [WIDTH-1:0] next_state;
    logic [WIDTH-1:0] seed_value;
    logic             fb;
    logic             step;
    logic             full;
    logic             state_zero;
    logic             seed_zero;

    assign fb         = ^(state & TAP_MASK);
    assign state_zero = (state == '0);
    assign next_state = state_zero ? SEED : {state[WIDTH-2:0], fb};
    assign seed_zero  = (bus.seed_data == '0);
    assign seed_value = seed_zero ? SEED : bus.seed_data;
    assign step       = en && !bus.seed_valid && !full;

    assign bus.seed_ready = rst_n;
    assign state_out      = state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= SEED;
            loaded_seed <= SEED;
            bit_out     <= 1'b0;
            bit_valid   <= 1'b0;
            period_done <= 1'b0;
            step_count  <= '0;
            lockup      <= 1'b0;
        end else begin
            bit_valid   <= step;
            period_done <= step && (next_state == loaded_seed);
            // A zero seed would freeze the register, so it is replaced and flagged.
            if (bus.seed_valid) begin
                state       <= seed_value;
                loaded_seed <= seed_value;
                step_count  <= '0;
                if (seed_zero) begin
                    lockup <= 1'b1;
                end
            end else if (step) begin
                state      <= next_state;
                bit_out    <= fb;
                step_count <= step_count + WIDTH'(1);
                if (state_zero) begin
                    lockup <= 1'b1;
                end
            end
        end
    end

    tt_lfsr_word_pack #(
        .OUT_W (OUT_W)
    ) u_word_pack (
        .clk        (clk),
        .rst_n      (rst_n),
        .step       (step),
        .fb         (fb),
        .clear      (bus.seed_valid),
        .word_ready (bus.word_ready),
        .word_data  (bus.word_data),
        .word_valid (bus.word_valid),
        .full       (full)
    );
endmodule

// File: tb/tb_tt_lfsr_gen.sv
// Self-checking bench for tt_lfsr_gen: directed scenarios plus randomized traffic,
// all compared against a queue-based behavioural model of the generator.
module tb_tt_lfsr_gen;
    localparam int          WIDTH    = 16;
    localparam int          OUT_W    = 8;
    localparam logic [15:0] TAPS     = 16'hD008;
    localparam logic [15:0] SEED_VAL = 16'h0001;
    localparam logic [44:0] RESET_OBS = {16'h0001, 16'h0000, 8'h00, 5'b00000};

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        en    = 1'b0;
    logic        bit_out;
    logic        bit_valid;
    logic        period_done;
    logic        lockup;
    logic [15:0] state_out;
    logic [15:0] step_count;

    int checks   = 0;
    int failures = 0;

    int unsigned m_state;
    int unsigned m_loaded;
    int unsigned m_count;
    int unsigned m_word;
    bit          m_bit;
    bit          m_bit_valid;
    bit          m_period;
    bit          m_lockup;
    bit          m_word_valid;
    int          m_bits[$];

    tt_lfsr_gen_if #(.WIDTH(WIDTH), .OUT_W(OUT_W)) bus ();

    tt_lfsr_gen #(
        .WIDTH    (WIDTH),
        .TAP_MASK (TAPS),
        .SEED     (SEED_VAL),
        .OUT_W    (OUT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .bus         (bus),
        .bit_out     (bit_out),
        .bit_valid   (bit_valid),
        .state_out   (state_out),
        .period_done (period_done),
        .step_count  (step_count),
        .lockup      (lockup)
    );

    always #5 clk = ~clk;

    function automatic logic [44:0] observed();
        return {state_out, step_count, bus.word_data, bit_out, bit_valid,
                bus.word_valid, period_done, lockup};
    endfunction

    function automatic logic [44:0] expected();
        return {16'(m_state), 16'(m_count), 8'(m_word), m_bit, m_bit_valid,
                m_word_valid, m_period, m_lockup};
    endfunction

    task automatic model_reset();
        m_state      = SEED_VAL;
        m_loaded     = SEED_VAL;
        m_count      = 0;
        m_word       = 0;
        m_bit        = 0;
        m_bit_valid  = 0;
        m_period     = 0;
        m_lockup     = 0;
        m_word_valid = 0;
        m_bits.delete();
    endtask

    // Advance the model by one clock using the inputs currently applied, then clock the DUT.
    task automatic tick();
        bit          full;
        bit          do_step;
        bit          fb;
        int unsigned nxt;
        if (!rst_n) begin
            model_reset();
        end else begin
            full        = m_word_valid && !bus.word_ready && (m_bits.size() == OUT_W - 1);
            do_step     = en && !bus.seed_valid && !full;
            m_bit_valid = do_step;
            m_period    = 0;
            if (m_word_valid && bus.word_ready) m_word_valid = 0;
            if (bus.seed_valid) begin
                if (bus.seed_data == 16'h0000) begin
                    m_state  = SEED_VAL;
                    m_lockup = 1;
                end else begin
                    m_state = bus.seed_data;
                end
                m_loaded = m_state;
                m_count  = 0;
                m_bits.delete();
            end else if (do_step) begin
                fb = ($countones(m_state & TAPS) % 2) == 1;
                if (m_state == 0) begin
                    nxt      = SEED_VAL;
                    m_lockup = 1;
                end else begin
                    nxt = (m_state * 2 + fb) % 65536;
                end
                m_state  = nxt;
                m_bit    = fb;
                m_count  = (m_count + 1) % 65536;
                m_period = (nxt == m_loaded);
                m_bits.push_back(int'(fb));
                if (m_bits.size() == OUT_W) begin
                    m_word = 0;
                    foreach (m_bits[i]) m_word = m_word * 2 + m_bits[i];
                    m_word_valid = 1;
                    m_bits.delete();
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1;
        bus.seed_valid = 1'b0; bus.seed_data = '0; bus.word_ready = 1'b1;
        tick(); tick();
        checks++;
        if (observed() !== RESET_OBS) begin
            failures++;
            $display("[TB] FAIL reset_in got %h want %h", observed(), RESET_OBS);
        end
        rst_n = 1'b1; en = 1'b0;
        tick();
        checks++;
        if (observed() !== RESET_OBS) begin
            failures++;
            $display("[TB] FAIL reset_out got %h want %h", observed(), RESET_OBS);
        end
        checks++;
        if (bus.seed_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL seed_ready got %b want 1", bus.seed_ready);
        end
    endtask

    task automatic test_first_steps();
        logic [15:0] exp_state[4] = '{16'h0002, 16'h0004, 16'h0008, 16'h0011};
        logic        exp_bit[4]   = '{1'b0, 1'b0, 1'b0, 1'b1};
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (state_out !== exp_state[i] || bit_out !== exp_bit[i] || bit_valid !== 1'b1) begin
                failures++;
                $display("[TB] FAIL first_step%0d got state=%h bit=%b v=%b want state=%h bit=%b v=1",
                         i, state_out, bit_out, bit_valid, exp_state[i], exp_bit[i]);
            end
        end
    endtask

    task automatic test_seed_word();
        bus.word_ready = 1'b1; en = 1'b1;
        bus.seed_valid = 1'b1; bus.seed_data = 16'hACE1;
        tick();
        bus.seed_valid = 1'b0;
        checks++;
        if (state_out !== 16'hACE1 || step_count !== 16'h0000 || bit_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL seed_load got state=%h cnt=%h v=%b want state=ace1 cnt=0000 v=0",
                     state_out, step_count, bit_valid);
        end
        for (int i = 0; i < 7; i++) tick();
        checks++;
        if (bus.word_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL word_early got valid=%b want 0", bus.word_valid);
        end
        tick();
        en = 1'b0;
        checks++;
        if (bus.word_valid !== 1'b1 || bus.word_data !== 8'(m_word)) begin
            failures++;
            $display("[TB] FAIL word_first got valid=%b data=%h want valid=1 data=%h",
                     bus.word_valid, bus.word_data, 8'(m_word));
        end
        tick();
        checks++;
        if (bus.word_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL word_one_cycle got valid=%b want 0", bus.word_valid);
        end
    endtask

    task automatic test_backpressure();
        int unsigned frozen;
        bus.word_ready = 1'b0; en = 1'b0;
        bus.seed_valid = 1'b1; bus.seed_data = 16'h1234;
        tick();
        bus.seed_valid = 1'b0; en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 14) frozen = m_state;
            checks++;
            if (state_out !== 16'(m_state)) begin
                failures++;
                $display("[TB] FAIL bp_state%0d got %h want %h", i, state_out, 16'(m_state));
            end
        end
        checks++;
        if (step_count !== 16'd15 || state_out !== 16'(frozen) || bus.word_valid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL bp_stall got cnt=%0d state=%h valid=%b want cnt=15 state=%h valid=1",
                     step_count, state_out, bus.word_valid, 16'(frozen));
        end
        bus.word_ready = 1'b1;
        tick();
        checks++;
        if (step_count !== 16'd16 || bus.word_valid !== 1'b1 || bus.word_data !== 8'(m_word)) begin
            failures++;
            $display("[TB] FAIL bp_release got cnt=%0d valid=%b data=%h want cnt=16 valid=1 data=%h",
                     step_count, bus.word_valid, bus.word_data, 8'(m_word));
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (observed() !== expected()) begin
                failures++;
                $display("[TB] FAIL bp_resume%0d got %h want %h", i, observed(), expected());
            end
        end
    endtask

    task automatic test_zero_seed();
        en = 1'b0;
        bus.seed_valid = 1'b1; bus.seed_data = 16'h0000;
        tick();
        bus.seed_valid = 1'b0;
        checks++;
        if (state_out !== 16'h0001 || lockup !== 1'b1) begin
            failures++;
            $display("[TB] FAIL zero_seed got state=%h lockup=%b want state=0001 lockup=1",
                     state_out, lockup);
        end
        en = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        bus.seed_valid = 1'b1; bus.seed_data = 16'h5A5A;
        tick();
        bus.seed_valid = 1'b0;
        checks++;
        if (lockup !== 1'b1 || state_out !== 16'h5A5A) begin
            failures++;
            $display("[TB] FAIL lockup_sticky got lockup=%b state=%h want lockup=1 state=5a5a",
                     lockup, state_out);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; en = 1'b0;
        tick();
        checks++;
        if (lockup !== 1'b0) begin
            failures++;
            $display("[TB] FAIL lockup_clear got %b want 0", lockup);
        end
    endtask

    task automatic test_reset_mid_word();
        en = 1'b1; bus.word_ready = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        checks++;
        if (bus.word_valid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL mid_pending got valid=%b want 1", bus.word_valid);
        end
        rst_n = 1'b0;
        tick();
        checks++;
        if (observed() !== RESET_OBS) begin
            failures++;
            $display("[TB] FAIL mid_reset got %h want %h", observed(), RESET_OBS);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (state_out !== 16'h0002 || bus.word_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL mid_restart got state=%h valid=%b want state=0002 valid=0",
                     state_out, bus.word_valid);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            en             = ($urandom_range(0, 3) != 0);
            bus.word_ready = ($urandom_range(0, 2) != 0);
            bus.seed_valid = ($urandom_range(0, 40) == 0);
            bus.seed_data  = ($urandom_range(0, 5) == 0) ? 16'h0000 : 16'($urandom);
            tick();
            checks++;
            if (observed() !== expected()) begin
                failures++;
                $display("[TB] FAIL rand%0d got %h want %h", i, observed(), expected());
            end
        end
        bus.seed_valid = 1'b0;
    endtask

    task automatic test_period();
        int first = 0;
        rst_n = 1'b0; en = 1'b0; bus.word_ready = 1'b1; bus.seed_valid = 1'b0;
        tick();
        rst_n = 1'b1; en = 1'b1;
        for (int i = 1; i <= 70000; i++) begin
            tick();
            if (period_done === 1'b1) begin
                first = i;
                break;
            end
        end
        checks++;
        if (first != 65535 || step_count !== 16'hFFFF || state_out !== 16'h0001 || lockup !== 1'b0) begin
            failures++;
            $display("[TB] FAIL period got step=%0d cnt=%h state=%h lockup=%b want step=65535 cnt=ffff state=0001 lockup=0",
                     first, step_count, state_out, lockup);
        end
        tick();
        checks++;
        if (period_done !== 1'b0 || step_count !== 16'h0000 || state_out !== 16'h0002) begin
            failures++;
            $display("[TB] FAIL period_wrap got pd=%b cnt=%h state=%h want pd=0 cnt=0000 state=0002",
                     period_done, step_count, state_out);
        end
    endtask

    initial begin
        bus.seed_valid = 1'b0;
        bus.seed_data  = '0;
        bus.word_ready = 1'b1;
        model_reset();
        test_reset();
        test_first_steps();
        test_seed_word();
        test_backpressure();
        test_zero_seed();
        test_reset_mid_word();
        test_random();
        test_period();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
